// File: rtl/mux_pkg.sv
// Shared arbitration-mode definitions and sizing helper for the stream mux.
package mux_pkg;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: round-robin from a rotating pointer, or fixed lowest-index priority.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned MODE     = MODE_RR,
  localparam int unsigned CW       = chan_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic                en,
  output logic [CHANNELS-1:0] grant,
  output logic [CW-1:0]       grant_idx
);

  localparam arb_mode_e ARB = (MODE == MODE_FIXED) ? ARB_FIXED : ARB_RR;

  logic [CW-1:0] ptr;
  logic [CW-1:0] cand;
  logic          found;

  // Scan upward from the pointer (or from 0 in fixed mode), wrapping at CHANNELS.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cand = (ARB == ARB_FIXED) ? CW'(k) : CW'((32'(ptr) + k) % CHANNELS);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 registered stream merge with valid/ready on every port and selectable arbitration.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned MODE     = MODE_RR,
  localparam int unsigned CW       = chan_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                load_en_c;
  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]       grant_idx;
  logic [WIDTH-1:0]    sel_data_c;

  // Output slot is free when empty or draining this cycle.
  assign load_en_c = !out_valid || out_ready;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .MODE     (MODE)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .en        (load_en_c && !reset),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign in_ready = reset ? '0 : (grant & {CHANNELS{load_en_c}});

  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sel_data_c = sel_data_c | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load_en_c) begin
      if (|grant) begin
        out_valid <= 1'b1;
        out_data  <= sel_data_c;
        out_chan  <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a round-robin and a fixed-priority instance share one stimulus.
module tb_stream_mux_rr;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic          out_ready;

  logic [N-1:0]  rdy [2];
  logic [W-1:0]  od  [2];
  logic [1:0]    oc  [2];
  logic          ov  [2];

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state: what each output register should hold.
  logic          m_valid [2];
  logic [W-1:0]  m_data  [2];
  logic [1:0]    m_chan  [2];
  int            m_ptr;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .CHANNELS(N), .MODE(0)) u_dut_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .out_data(od[0]), .out_chan(oc[0]), .out_valid(ov[0]),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(W), .CHANNELS(N), .MODE(1)) u_dut_fix (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .out_data(od[1]), .out_chan(oc[1]), .out_valid(ov[1]),
    .out_ready(out_ready)
  );

  function automatic logic [W-1:0] chd(input int i);
    return in_data[i*W +: W];
  endfunction

  // Winning channel for instance d (0 = round-robin, 1 = fixed), -1 when nothing is valid.
  function automatic int winner(input int d);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (d == 1) ? k : (m_ptr + k) % N;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int d);
    int w;
    w = winner(d);
    if (reset || w < 0 || (m_valid[d] && !out_ready)) return '0;
    return N'(1 << w);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int w;
      w = winner(d);
      if (reset) begin
        m_valid[d] = 1'b0;
        m_data[d]  = '0;
        m_chan[d]  = '0;
        if (d == 0) m_ptr = 0;
      end else if (!m_valid[d] || out_ready) begin
        if (w >= 0) begin
          m_valid[d] = 1'b1;
          m_data[d]  = chd(w);
          m_chan[d]  = 2'(w);
          if (d == 0) m_ptr = (w + 1) % N;
        end else begin
          m_valid[d] = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = {$urandom, $urandom};
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        compared++;
        if (rdy[d] !== 4'h0 || ov[d] !== 1'b0 || od[d] !== 16'h0) begin
          mismatched++;
          $display("FAIL reset_hold dut%0d: ready=%b valid=%b data=%h required 0000/0/0000", d, rdy[d], ov[d], od[d]);
        end
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (rdy[d] !== 4'b0001) begin
        mismatched++;
        $display("FAIL reset_first_grant dut%0d: ready=%b required 0001", d, rdy[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    in_valid = 4'b0100; out_ready = 1'b1;
    in_data = {$urandom, $urandom}; in_data[2*W +: W] = 16'hA5A5;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (rdy[d] !== 4'b0100) begin
        mismatched++;
        $display("FAIL single_ready dut%0d: ready=%b required 0100", d, rdy[d]);
      end
    end
    @(posedge clk); #1;
    in_valid = 4'b0000;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (ov[d] !== 1'b1 || od[d] !== 16'hA5A5 || oc[d] !== 2'd2) begin
        mismatched++;
        $display("FAIL single_out dut%0d: valid=%b data=%h chan=%0d required 1/a5a5/2", d, ov[d], od[d], oc[d]);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (ov[d] !== 1'b0 || od[d] !== 16'hA5A5) begin
        mismatched++;
        $display("FAIL single_drain dut%0d: valid=%b data=%h required 0/a5a5", d, ov[d], od[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rr_wrap();
    logic [N*W-1:0] snap;
    reset = 1'b1; in_valid = 4'h0;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {$urandom, $urandom}; snap = in_data;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (ov[0] !== 1'b1 || oc[0] !== 2'(i % 4) || od[0] !== snap[(i % 4)*W +: W]) begin
        mismatched++;
        $display("FAIL rr_wrap step%0d: valid=%b chan=%0d data=%h required 1/%0d/%h", i, ov[0], oc[0], od[0], i % 4, snap[(i % 4)*W +: W]);
      end
      compared++;
      if (ov[1] !== 1'b1 || oc[1] !== 2'd0) begin
        mismatched++;
        $display("FAIL fixed_all_valid step%0d: valid=%b chan=%0d required 1/0", i, ov[1], oc[1]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ch2;
    in_valid = 4'b0010; in_data[1*W +: W] = 16'h1234;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        compared++;
        if (ov[d] !== 1'b1 || od[d] !== 16'h1234 || oc[d] !== 2'd1 || rdy[d] !== 4'h0) begin
          mismatched++;
          $display("FAIL backpressure dut%0d cyc%0d: valid=%b data=%h chan=%0d ready=%b required 1/1234/1/0000", d, i, ov[d], od[d], oc[d], rdy[d]);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; ch2 = chd(2);
    @(negedge clk);
    compared++;
    if (rdy[0] !== 4'b0100 || rdy[1] !== 4'b0001) begin
      mismatched++;
      $display("FAIL release_ready: rr=%b fix=%b required 0100/0001", rdy[0], rdy[1]);
    end
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (oc[0] !== 2'd2 || od[0] !== ch2 || ov[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL release_load: chan=%0d data=%h valid=%b required 2/%h/1", oc[0], od[0], ov[0], ch2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fixed();
    in_valid = 4'b1010; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (ov[1] !== 1'b1 || oc[1] !== 2'd1) begin
        mismatched++;
        $display("FAIL fixed_prio cyc%0d: valid=%b chan=%0d required 1/1", i, ov[1], oc[1]);
      end
    end
    @(posedge clk); #1;
    in_valid = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (ov[1] !== 1'b1 || oc[1] !== 2'd3) begin
      mismatched++;
      $display("FAIL fixed_drop: valid=%b chan=%0d required 1/3", ov[1], oc[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 1'b0; in_valid = 4'hF; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (ov[d] !== 1'b0 || od[d] !== 16'h0 || rdy[d] !== 4'b0001) begin
        mismatched++;
        $display("FAIL reset_mid dut%0d: valid=%b data=%h ready=%b required 0/0000/0001", d, ov[d], od[d], rdy[d]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (ov[d] !== 1'b1 || oc[d] !== 2'd0) begin
        mismatched++;
        $display("FAIL reset_mid_grant dut%0d: valid=%b chan=%0d required 1/0", d, ov[d], oc[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        compared++;
        if (rdy[d] !== exp_ready(d)) begin
          mismatched++;
          $display("FAIL rand_ready dut%0d it%0d: got %b required %b", d, n, rdy[d], exp_ready(d));
        end
        compared++;
        if (ov[d] !== m_valid[d] || od[d] !== m_data[d] || oc[d] !== m_chan[d]) begin
          mismatched++;
          $display("FAIL rand_out dut%0d it%0d: got %b/%h/%0d required %b/%h/%0d", d, n, ov[d], od[d], oc[d], m_valid[d], m_data[d], m_chan[d]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_data[d] = '0; m_chan[d] = '0;
    end
    m_ptr = 0;
    test_reset();
    test_single();
    test_rr_wrap();
    test_backpressure();
    test_fixed();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
